// File: rtl/mem_access_unit_if.sv
// -----------------------------------------------------------------------------
// mem_access_unit_if
// Purpose : data-SRAM request/response bus between the memory access unit
//           (master) and the data SRAM (slave).
// Signals : data_sram_req/wr/wstrb/addr/wdata  master -> slave request fields
//           data_sram_addr_ok                  slave accepted the request
//           data_sram_data_ok/rdata            slave returns the response
// -----------------------------------------------------------------------------
interface mem_access_unit_if;
    logic        data_sram_req;
    logic        data_sram_wr;
    logic [3:0]  data_sram_wstrb;
    logic [31:0] data_sram_addr;
    logic [31:0] data_sram_wdata;
    logic        data_sram_addr_ok;
    logic        data_sram_data_ok;
    logic [31:0] data_sram_rdata;

    modport master (
        output data_sram_req, data_sram_wr, data_sram_wstrb,
               data_sram_addr, data_sram_wdata,
        input  data_sram_addr_ok, data_sram_data_ok, data_sram_rdata
    );

    modport slave (
        input  data_sram_req, data_sram_wr, data_sram_wstrb,
               data_sram_addr, data_sram_wdata,
        output data_sram_addr_ok, data_sram_data_ok, data_sram_rdata
    );
endinterface

// File: rtl/mem_access_unit.sv
// -----------------------------------------------------------------------------
// mem_access_unit
// Purpose : executes MIPS-style loads/stores (LB/LH/LW/LBU/LHU/SB/SH/SW) over
//           a split address/data handshake SRAM bus, with alignment
//           exceptions, pipeline stall and flush/drain handling.
// Ports   : clk, rst          clock, asynchronous active-high reset
//           mem_en, mem_wr    access present / store(1) vs load(0)
//           op, addr, wdata   opcode, effective address, store data
//           flush             cancel the current access
//           sram              data-SRAM bus (master side)
//           rdata             formatted load result
//           done, stall       access complete / hold the pipeline
//           adel, ades        load / store address-error pulse
//           bad_addr          faulting address during adel/ades
// -----------------------------------------------------------------------------
module mem_access_unit (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     mem_en,
    input  logic                     mem_wr,
    input  logic [5:0]               op,
    input  logic [31:0]              addr,
    input  logic [31:0]              wdata,
    input  logic                     flush,
    mem_access_unit_if.master        sram,
    output logic [31:0]              rdata,
    output logic                     done,
    output logic                     stall,
    output logic                     adel,
    output logic                     ades,
    output logic [31:0]              bad_addr
);

    typedef enum logic [2:0] {
        S_IDLE, S_REQ, S_WAIT, S_RESP, S_DRAIN
    } state_t;

    state_t      r_state;
    state_t      w_next;

    logic [5:0]  r_op;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic        r_wr;
    logic [31:0] r_rdata;

    logic        w_aligned;
    logic        w_access;
    logic        w_start;
    logic        w_misalign;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load_fmt;

    // op[1:0] encodes access size for every supported opcode: 00 byte,
    // 01 halfword, 11 word.
    always_comb begin
        case (op[1:0])
            2'b00:   w_aligned = 1'b1;
            2'b01:   w_aligned = ~addr[0];
            default: w_aligned = (addr[1:0] == 2'b00);
        endcase
    end

    // Gated by rst so that no input-driven output can leak out during reset.
    assign w_access   = mem_en & ~flush & ~rst & (r_state == S_IDLE);
    assign w_start    = w_access & w_aligned;
    assign w_misalign = w_access & ~w_aligned;

    // ---------------- state register ----------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of block ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    // ---------------- next-state logic ----------------
    // NOTE: w_next gets a default before the case so no path infers a latch.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_start) w_next = S_REQ;
            S_REQ: begin
                if (flush)          w_next = sram.data_sram_addr_ok ? S_DRAIN : S_IDLE;
                else if (sram.data_sram_addr_ok) w_next = S_WAIT;
            end
            S_WAIT: begin
                if (sram.data_sram_data_ok) w_next = flush ? S_IDLE : S_RESP;
                else if (flush)             w_next = S_DRAIN;
            end
            S_RESP:  w_next = S_IDLE;
            S_DRAIN: if (sram.data_sram_data_ok) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // ---------------- outputs ----------------
    always_comb begin
        sram.data_sram_req = 1'b0;
        done               = 1'b0;
        stall              = 1'b0;
        adel               = w_misalign & ~mem_wr;
        ades               = w_misalign &  mem_wr;
        bad_addr           = w_misalign ? addr : 32'h0;
        case (r_state)
            S_IDLE: begin
                done  = w_misalign;
                stall = w_start;
            end
            S_REQ: begin
                sram.data_sram_req = 1'b1;
                stall              = 1'b1;
            end
            S_WAIT:  stall = 1'b1;
            S_RESP:  done  = 1'b1;
            S_DRAIN: stall = mem_en;
            default: ;
        endcase
    end

    // ---------------- request fields ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op    <= 6'h0;
            r_addr  <= 32'h0;
            r_wdata <= 32'h0;
            r_wr    <= 1'b0;
        end else if (w_start) begin
            r_op    <= op;
            r_addr  <= addr;
            r_wdata <= wdata;
            r_wr    <= mem_wr;
        end
    end

    assign sram.data_sram_addr = r_addr;
    assign sram.data_sram_wr   = r_wr;

    // Store lanes: replicate the narrow data across the word; the strobe picks
    // the lane the SRAM actually writes.
    always_comb begin
        case (r_op[1:0])
            2'b00: begin
                sram.data_sram_wstrb = 4'b0001 << r_addr[1:0];
                sram.data_sram_wdata = {4{r_wdata[7:0]}};
            end
            2'b01: begin
                sram.data_sram_wstrb = r_addr[1] ? 4'b1100 : 4'b0011;
                sram.data_sram_wdata = {2{r_wdata[15:0]}};
            end
            default: begin
                sram.data_sram_wstrb = 4'b1111;
                sram.data_sram_wdata = r_wdata;
            end
        endcase
        if (!r_wr) sram.data_sram_wstrb = 4'b0000;
    end

    // ---------------- load formatting ----------------
    assign w_byte = sram.data_sram_rdata[{r_addr[1:0], 3'b000} +: 8];
    assign w_half = sram.data_sram_rdata[{r_addr[1], 4'b0000} +: 16];

    // r_op[2] marks the unsigned variants (LBU/LHU).
    always_comb begin
        case (r_op[2:0])
            3'b000:  w_load_fmt = {{24{w_byte[7]}}, w_byte};
            3'b001:  w_load_fmt = {{16{w_half[15]}}, w_half};
            3'b100:  w_load_fmt = {24'h0, w_byte};
            3'b101:  w_load_fmt = {16'h0, w_half};
            default: w_load_fmt = sram.data_sram_rdata;
        endcase
    end

    // Only a live (non-flushed) load response updates rdata; drained data and
    // store acknowledgements are discarded.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_rdata <= 32'h0;
        else if (r_state == S_WAIT && sram.data_sram_data_ok && !flush && !r_wr)
            r_rdata <= w_load_fmt;
    end

    assign rdata = r_rdata;

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

    localparam logic [5:0] LB  = 6'b100000, LH  = 6'b100001, LW  = 6'b100011,
                           LBU = 6'b100100, LHU = 6'b100101,
                           SB  = 6'b101000, SH  = 6'b101001, SW  = 6'b101011;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_en, mem_wr, flush;
    logic [5:0]  op;
    logic [31:0] addr, wdata;
    logic [31:0] rdata, bad_addr;
    logic        done, stall, adel, ades;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] exp_rdata = 32'h0;
    logic [5:0]  ops [8] = '{LB, LH, LW, LBU, LHU, SB, SH, SW};

    mem_access_unit_if sram ();

    mem_access_unit dut (
        .clk      (clk),
        .rst      (rst),
        .mem_en   (mem_en),
        .mem_wr   (mem_wr),
        .op       (op),
        .addr     (addr),
        .wdata    (wdata),
        .flush    (flush),
        .sram     (sram),
        .rdata    (rdata),
        .done     (done),
        .stall    (stall),
        .adel     (adel),
        .ades     (ades),
        .bad_addr (bad_addr)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic bit is_store(input logic [5:0] o);
        return (o == SB || o == SH || o == SW);
    endfunction

    function automatic int size_of(input logic [5:0] o);
        if (o == LB || o == LBU || o == SB) return 1;
        if (o == LH || o == LHU || o == SH) return 2;
        return 4;
    endfunction

    function automatic bit misaligned(input logic [5:0] o, input logic [31:0] a);
        return (a % size_of(o)) != 0;
    endfunction

    function automatic logic [31:0] ref_load(input logic [5:0] o, input logic [31:0] a,
                                             input logic [31:0] word);
        int unsigned off = a % 4;
        longint v;
        case (o)
            LB, LBU: begin
                v = longint'((word >> (8 * off)) & 32'hFF);
                if (o == LB && v > 127) v -= 256;
            end
            LH, LHU: begin
                v = longint'((word >> (16 * (off / 2))) & 32'hFFFF);
                if (o == LH && v > 32767) v -= 65536;
            end
            default: v = longint'(word);
        endcase
        return v[31:0];
    endfunction

    function automatic logic [31:0] ref_wstrb(input logic [5:0] o, input logic [31:0] a);
        int unsigned off = a % 4;
        if (!is_store(o)) return 32'h0;
        if (o == SB) return 32'h1 << off;
        if (o == SH) return (off >= 2) ? 32'hC : 32'h3;
        return 32'hF;
    endfunction

    function automatic logic [31:0] ref_wdata(input logic [5:0] o, input logic [31:0] wd);
        if (o == SB) return (wd & 32'hFF) * 32'h01010101;
        if (o == SH) return (wd & 32'hFFFF) * 32'h00010001;
        return wd;
    endfunction

    // ---------------- helpers ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        mem_en = 1'b0; mem_wr = 1'b0; flush = 1'b0;
        sram.data_sram_addr_ok = 1'b0;
        sram.data_sram_data_ok = 1'b0;
    endtask

    task automatic start(input logic [5:0] o, input logic [31:0] a, input logic [31:0] wd);
        cyc();
        idle_inputs();
        mem_en = 1'b1; mem_wr = is_store(o); op = o; addr = a; wdata = wd;
    endtask

    // One complete access: start cycle, REQ cycles, WAIT cycles, RESP cycle.
    task automatic do_access(input logic [5:0] o, input logic [31:0] a, input logic [31:0] wd,
                             input logic [31:0] word, input int ao_dly, input int do_dly,
                             input bit flush_resp);
        bit st  = is_store(o);
        bit mis = misaligned(o, a);
        start(o, a, wd);
        #2;
        check("start_stall", stall, !mis);
        check("start_done", done, mis);
        check("start_adel", adel, mis && !st);
        check("start_ades", ades, mis && st);
        check("start_req", sram.data_sram_req, 0);
        if (mis) begin
            check("bad_addr", bad_addr, a);
            return;
        end
        for (int i = 0; i <= ao_dly; i++) begin
            cyc();
            sram.data_sram_addr_ok = (i == ao_dly);
            sram.data_sram_data_ok = 1'($urandom_range(0, 1));
            #2;
            check("req_req", sram.data_sram_req, 1);
            check("req_addr", sram.data_sram_addr, a);
            check("req_wr", sram.data_sram_wr, st);
            check("req_wstrb", sram.data_sram_wstrb, ref_wstrb(o, a));
            if (st) check("req_wdata", sram.data_sram_wdata, ref_wdata(o, wd));
            check("req_stall", stall, 1);
            check("req_done", done, 0);
        end
        for (int i = 0; i <= do_dly; i++) begin
            cyc();
            sram.data_sram_addr_ok = 1'($urandom_range(0, 1));
            sram.data_sram_data_ok = (i == do_dly);
            sram.data_sram_rdata   = (i == do_dly) ? word : $urandom;
            #2;
            check("wait_req", sram.data_sram_req, 0);
            check("wait_stall", stall, 1);
            check("wait_done", done, 0);
        end
        cyc();
        idle_inputs();
        mem_en = 1'($urandom_range(0, 1));
        flush  = flush_resp;
        if (!st) exp_rdata = ref_load(o, a, word);
        #2;
        check("resp_done", done, 1);
        check("resp_stall", stall, 0);
        check("resp_rdata", rdata, exp_rdata);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b1; op = 6'h0; addr = 32'h0; wdata = 32'h0;
        sram.data_sram_rdata = 32'h0;
        idle_inputs();
        #3;
        check("rst_req", sram.data_sram_req, 0);
        check("rst_stall", stall, 0);
        check("rst_done", done, 0);
        check("rst_rdata", rdata, 0);
        check("rst_bad_addr", bad_addr, 0);
        check("rst_addr", sram.data_sram_addr, 0);
        cyc();
        cyc();
        rst = 1'b0;

        // Minimum latency LW and the load formatting vectors
        do_access(LW, 32'h0000_0104, 0, 32'hDEAD_BEEF, 0, 0, 0);
        check("lw_deadbeef", rdata, 32'hDEAD_BEEF);
        do_access(LB, 32'h0000_0203, 0, 32'h80FF_0011, 0, 0, 0);
        check("lb_sign", rdata, 32'hFFFF_FF80);
        do_access(LBU, 32'h0000_0203, 0, 32'h80FF_0011, 1, 2, 0);
        check("lbu_zero", rdata, 32'h0000_0080);
        do_access(LHU, 32'h0000_0202, 0, 32'h80FF_0011, 0, 1, 0);
        check("lhu_zero", rdata, 32'h0000_80FF);

        // Store lanes (store leaves rdata alone)
        do_access(SB, 32'h0000_0302, 32'h0000_00AB, 32'h1234_5678, 0, 0, 0);
        do_access(SH, 32'h0000_0302, 32'h0000_CDEF, 32'h1234_5678, 2, 0, 0);
        check("store_keeps_rdata", rdata, 32'h0000_80FF);

        // Alignment exceptions
        do_access(LW, 32'h0000_0102, 0, 0, 0, 0, 0);
        do_access(SH, 32'h0000_0101, 0, 0, 0, 0, 0);

        // Flush in IDLE suppresses exception and start
        cyc();
        mem_en = 1'b1; op = LW; addr = 32'h0000_0102; flush = 1'b1; mem_wr = 1'b0;
        #2;
        check("fidle_adel", adel, 0);
        check("fidle_done", done, 0);
        check("fidle_bad_addr", bad_addr, 0);
        addr = 32'h0000_0100;
        #1;
        check("fidle_stall", stall, 0);
        cyc();
        idle_inputs();
        #2;
        check("fidle_no_req", sram.data_sram_req, 0);

        // Flush in REQ without addr_ok -> IDLE; data_ok in IDLE ignored
        start(LW, 32'h0000_0200, 0);
        cyc();
        flush = 1'b1;
        cyc();
        idle_inputs();
        sram.data_sram_data_ok = 1'b1;
        #2;
        check("freq_req_dropped", sram.data_sram_req, 0);
        check("freq_stall", stall, 0);
        check("freq_done", done, 0);

        // Flush in REQ with addr_ok -> DRAIN, flush in DRAIN has no effect
        start(LH, 32'h0000_0202, 0);
        cyc();
        flush = 1'b1; sram.data_sram_addr_ok = 1'b1;
        cyc();
        idle_inputs();
        #2;
        check("drain_req", sram.data_sram_req, 0);
        check("drain_stall_idle", stall, 0);
        check("drain_done", done, 0);
        cyc();
        flush = 1'b1; sram.data_sram_data_ok = 1'b1; sram.data_sram_rdata = 32'h1234_5678;
        #2;
        check("drain_end_done", done, 0);
        cyc();
        idle_inputs();
        #2;
        check("drain_rdata_kept", rdata, exp_rdata);
        check("drain_after_done", done, 0);

        // Flush in WAIT with data_ok in the same cycle -> IDLE, data discarded
        start(LW, 32'h0000_0300, 0);
        cyc();
        sram.data_sram_addr_ok = 1'b1;
        cyc();
        idle_inputs();
        flush = 1'b1; sram.data_sram_data_ok = 1'b1; sram.data_sram_rdata = 32'h5555_AAAA;
        #2;
        check("fwait_done", done, 0);
        cyc();
        idle_inputs();
        #2;
        check("fwait_done2", done, 0);
        check("fwait_stall", stall, 0);
        check("fwait_rdata", rdata, exp_rdata);

        // Flush in WAIT, data_ok three cycles later; new LW stalls until drained
        start(LW, 32'h0000_0300, 0);
        cyc();
        sram.data_sram_addr_ok = 1'b1;
        cyc();
        idle_inputs();
        flush = 1'b1;
        cyc();
        idle_inputs();
        #2;
        check("d37_stall0", stall, 0);
        check("d37_done0", done, 0);
        cyc();
        mem_en = 1'b1; op = LW; addr = 32'h0000_0400; mem_wr = 1'b0;
        #2;
        check("d37_stall1", stall, 1);
        check("d37_req", sram.data_sram_req, 0);
        cyc();
        sram.data_sram_data_ok = 1'b1; sram.data_sram_rdata = 32'h0BAD_F00D;
        #2;
        check("d37_stall2", stall, 1);
        check("d37_done2", done, 0);
        do_access(LW, 32'h0000_0400, 0, 32'h0246_8ACE, 0, 0, 0);

        // Flush in RESP is ignored
        do_access(LHU, 32'h0000_0500, 0, 32'h0000_9876, 0, 0, 1);

        // Randomized accesses against the reference model
        for (int n = 0; n < 40; n++) begin
            do_access(ops[$urandom_range(0, 7)], $urandom, $urandom, $urandom,
                      $urandom_range(0, 2), $urandom_range(0, 2), 1'($urandom_range(0, 1)));
        end

        // Reset in WAIT abandons the access; late data_ok ignored
        start(LW, 32'h0000_0600, 0);
        cyc();
        sram.data_sram_addr_ok = 1'b1;
        cyc();
        idle_inputs();
        #2;
        rst = 1'b1;
        #1;
        exp_rdata = 32'h0;
        check("arst_stall", stall, 0);
        check("arst_req", sram.data_sram_req, 0);
        check("arst_done", done, 0);
        check("arst_rdata", rdata, 0);
        check("arst_addr", sram.data_sram_addr, 0);
        check("arst_wstrb", sram.data_sram_wstrb, 0);
        cyc();
        cyc();
        rst = 1'b0;
        cyc();
        sram.data_sram_data_ok = 1'b1; sram.data_sram_rdata = 32'hCAFE_0001;
        #2;
        check("late_dok_done", done, 0);
        check("late_dok_stall", stall, 0);
        cyc();
        idle_inputs();
        #2;
        check("late_dok_done2", done, 0);
        check("late_dok_rdata", rdata, exp_rdata);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
